// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO + handshake FSM feeding the UART Tx controller. A write lands in the FIFO, and TxStart is set one cycle later.
// Writes while full are dropped and flagged. Pops wait for TxEnable and for the previous byte to complete.
module uart_tx_fifo_ctrl #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          DSP_CLK,
    input  logic          RESET,
    input  logic          DSP_CEn,
    input  logic [4:1]    DSP_ADDR,
    input  logic          DSP_WEn,
    input  logic [15:0]   DSP_WDATA,
    output logic [15:0]   DSP_RDATA,
    input  logic          FIFOEn,
    input  logic          TxEnable,
    input  logic          TxFIFO_Flush,
    input  logic          TxBusy,
    input  logic          TxDone,
    output logic          TxStart,
    output logic [7:0]    TxData,
    output logic          TxFIFO_Empty,
    output logic          TxFIFO_Full,
    output logic [AW:0]   TxFIFO_Level,
    output logic          TxIdle,
    output logic          WriteDropError
);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} txState_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

    txState_t               state;
    logic [AW:0]            wp, rp;
    logic [7:0]             fifoMem [DEPTH];
    logic [SYNC_STAGES-1:0] busySync, doneSync;
    logic                   sTxBusy, sTxDone, sTxDone_d, doneRise;
    logic                   wrReq, wrAccept, wrDrop, popReq;
    logic [4:0]             statLevel;
    logic                   unusedWdata;

    assign TxFIFO_Level = wp - rp;
    assign TxFIFO_Empty = (TxFIFO_Level == '0);
    assign TxFIFO_Full  = FIFOEn ? (TxFIFO_Level == FULL_LEVEL) : !TxFIFO_Empty;
    assign TxIdle       = TxFIFO_Empty && (state == IDLE);

    assign sTxBusy  = busySync[SYNC_STAGES-1];
    assign sTxDone  = doneSync[SYNC_STAGES-1];
    assign doneRise = sTxDone && !sTxDone_d;

    // Full is judged on the registered level, so a same-cycle pop never rescues a write
    assign wrReq    = !DSP_CEn && !DSP_WEn && (DSP_ADDR == 4'd0);
    assign wrAccept = wrReq && !TxFIFO_Full && !TxFIFO_Flush;
    assign wrDrop   = wrReq && TxFIFO_Full && !TxFIFO_Flush;
    assign popReq   = (state == IDLE) && !TxFIFO_Empty && TxEnable && !TxFIFO_Flush;

    assign statLevel   = 5'(TxFIFO_Level);
    assign unusedWdata = ^DSP_WDATA[15:8];

    always_ff @(posedge DSP_CLK) begin
        if (wrAccept) begin
            fifoMem[wp[AW-1:0]] <= DSP_WDATA[7:0];
        end
    end

    always_ff @(posedge DSP_CLK) begin
        if (RESET) begin
            wp             <= '0;
            rp             <= '0;
            state          <= IDLE;
            TxStart        <= 1'b0;
            TxData         <= 8'd0;
            WriteDropError <= 1'b0;
            DSP_RDATA      <= 16'd0;
            busySync       <= '0;
            doneSync       <= '0;
            sTxDone_d      <= 1'b0;
        end else begin
            busySync  <= {busySync[SYNC_STAGES-2:0], TxBusy};
            doneSync  <= {doneSync[SYNC_STAGES-2:0], TxDone};
            sTxDone_d <= sTxDone;

            if (wrAccept) begin
                wp             <= wp + PTR_ONE;
                WriteDropError <= 1'b0;
            end else if (wrDrop) begin
                WriteDropError <= 1'b1;
            end

            if (TxFIFO_Flush) begin
                rp <= wp;
            end else if (popReq) begin
                rp <= rp + PTR_ONE;
            end

            case (state)
                IDLE: begin
                    if (popReq) begin
                        TxData  <= fifoMem[rp[AW-1:0]];
                        TxStart <= 1'b1;
                        state   <= REQ;
                    end
                end
                // A done edge before busy was seen means the whole transfer slipped past the synchronizers
                REQ: begin
                    if (doneRise) begin
                        TxStart <= 1'b0;
                        state   <= IDLE;
                    end else if (sTxBusy) begin
                        TxStart <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (doneRise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    TxStart <= 1'b0;
                    state   <= IDLE;
                end
            endcase

            if (!DSP_CEn && DSP_WEn) begin
                case (DSP_ADDR)
                    4'd0:    DSP_RDATA <= {8'd0, TxData};
                    4'd1:    DSP_RDATA <= {8'd0, statLevel, TxIdle, TxFIFO_Full, WriteDropError};
                    default: DSP_RDATA <= 16'd0;
                endcase
            end else begin
                DSP_RDATA <= 16'd0;
            end
        end
    end

endmodule
